arbitro_escritura_banco: RTL and testbench
==========================================

ARBITRO_ESCRITURA_BANCO -- requirements
Module: arbitro_escritura_banco

Interface
REQ-001 SHALL have parameter N, default 4: data width of banco_de_registros.
REQ-002 SHALL have parameter M, default 4: address width; bank depth 2^M.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have ports req0, req1  in  1 each: write requests from requesters 0 and 1.
REQ-006 SHALL have ports addr0, addr1  in  M each: target register addresses, held with req.
REQ-007 SHALL have ports data0, data1  in  N each: write data, held with req.
REQ-008 SHALL have port clr_req  in  1: request to zero every bank register.
REQ-009 SHALL have ports ack0, ack1  out  1 each: one-cycle pulse when that requester's write is issued.
REQ-010 SHALL have ports we, addr_rd, data_in  out  1/M/N: drive bank write port directly.
REQ-011 SHALL have port busy  out  1: high while in WRITE or CLEAR.
REQ-012 SHALL have port clr_done  out  1: one-cycle pulse on the final clear write.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, CLEAR; all outputs registered.
REQ-014 In IDLE with clr_req=1, SHALL enter CLEAR regardless of req0/req1; clear has priority.
REQ-015 In IDLE with clr_req=0 and any req, SHALL latch winner's addr/data and enter WRITE next cycle.
REQ-016 Single requester active: that requester wins.
REQ-017 Both active: winner = requester indicated by round-robin pointer ptr (0 or 1).
REQ-018 In WRITE (exactly one cycle), SHALL assert we=1, addr_rd/data_in = latched values, ack of winner=1; ptr set to the other requester; next state IDLE.
REQ-019 Latency: req sampled in IDLE at edge t -> we/ack high during cycle t+1; max one write per 2 cycles.
REQ-020 Requester SHALL hold req/addr/data until ack; requester deasserts or issues new req the cycle after ack; a req still high in the IDLE cycle after ack is treated as a new request.
REQ-021 In CLEAR, SHALL assert we=1, data_in=0, addr_rd = counter starting 0, incrementing by 1 each cycle, for 2^M consecutive cycles.
REQ-022 On the cycle addr_rd = 2^M-1 in CLEAR, SHALL pulse clr_done=1 and return to IDLE next; counter wraps to 0.
REQ-023 clr_req and req arriving during WRITE or CLEAR SHALL be ignored until IDLE; clr_req held high after clr_done restarts a new clear.
REQ-024 In IDLE, we=0, ack0=ack1=0, clr_done=0, busy=0; addr_rd/data_in hold last values.
REQ-025 ptr SHALL be unaffected by CLEAR.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, ptr=0, clear counter=0, we=0, ack0=ack1=0, busy=0, clr_done=0, addr_rd=0, data_in=0.
REQ-027 rst mid-WRITE or mid-CLEAR SHALL abort immediately; no ack or clr_done for the aborted operation; partial clear is not resumed.
REQ-028 rst SHALL take priority over all other inputs.

Structure
REQ-029 FSM state encodings SHALL live in a shared package/include as named constants; N, M remain module parameters.
REQ-030 SHALL be one module; no sub-modules; banco_de_registros instantiated by the parent alongside it.

Verification
REQ-031 req0=1, addr0=3, data0=A, IDLE -> next cycle we=1, addr_rd=3, data_in=A, ack0=1, ack1=0; then IDLE.
REQ-032 req0, req1 both held high from reset -> acks alternate ack0, ack1, ack0 ... one ack every 2 cycles.
REQ-033 clr_req=1 with req1=1 same cycle, M=4 -> 16 cycles we=1, data_in=0, addr_rd 0..15, clr_done on addr 15, then ack1 after return to IDLE.
REQ-034 rst at clear address 7 -> next cycle we=0, busy=0, clr_done never pulses, addr_rd=0.
REQ-035 req1 asserted during WRITE of requester 0 -> ignored until IDLE, then granted; ack1 two cycles after ack0.
REQ-036 Scoreboard model of 2^M registers, checked against bank read ports after random req/clr traffic -> all contents match.

Source files
------------

// File: rtl/arbitro_escritura_banco_pkg.sv
// Shared definitions for the register-bank write arbiter.
// Holds the FSM state encodings, the requester identifiers and the
// two-requester round-robin winner selection used by the arbiter.
package arbitro_escritura_banco_pkg;

  // FSM state encodings, shared so the parent and any monitors can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_CLEAR = 2'b10
  } estado_t;

  // Requester identifiers, also the encoding of the round-robin pointer.
  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

  // Winner among two requesters: a lone requester always wins; when both are
  // active the round-robin pointer decides. Only meaningful if req0|req1.
  function automatic logic elige_ganador(input logic req0,
                                         input logic req1,
                                         input logic ptr);
    if (req0 && req1) begin
      return ptr;
    end else if (req1) begin
      return REQ_1;
    end else begin
      return REQ_0;
    end
  endfunction

endpackage

// File: rtl/arbitro_escritura_banco.sv
// Write arbiter for a 2^M x N register bank: two round-robin requesters plus a
// full-bank clear that has priority over both.
// Ports: clk/rst (sync, active-high); req0/req1 with addr0/addr1 and
// data0/data1 held until ack0/ack1; clr_req starts a clear; we/addr_rd/data_in
// drive the bank write port; busy flags WRITE/CLEAR; clr_done marks the last
// clear write. All outputs are registered: a request sampled in IDLE at edge t
// shows we/ack during cycle t+1, so at most one write every two cycles.
module arbitro_escritura_banco #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [M-1:0] addr0,
  input  logic [M-1:0] addr1,
  input  logic [N-1:0] data0,
  input  logic [N-1:0] data1,
  input  logic         clr_req,
  output logic         ack0,
  output logic         ack1,
  output logic         we,
  output logic [M-1:0] addr_rd,
  output logic [N-1:0] data_in,
  output logic         busy,
  output logic         clr_done
);

  import arbitro_escritura_banco_pkg::*;

  // Highest bank address; the clear sweep ends on it. M >= 1 is assumed.
  localparam logic [M-1:0] ULTIMA = {M{1'b1}};

  estado_t        estado;
  estado_t        estado_nx;

  logic           ptr;
  logic           ptr_nx;
  logic [M-1:0]   cnt;
  logic [M-1:0]   cnt_nx;
  logic [M-1:0]   cnt_inc;
  logic           gana;

  // Next values of the registered outputs.
  logic           we_nx;
  logic           ack0_nx;
  logic           ack1_nx;
  logic           busy_nx;
  logic           clr_done_nx;
  logic [M-1:0]   addr_nx;
  logic [N-1:0]   data_nx;

  assign gana    = elige_ganador(req0, req1, ptr);
  assign cnt_inc = cnt + M'(1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= ST_IDLE;
    end else begin
      estado <= estado_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Inputs are only looked at in IDLE; anything arriving
  // during WRITE or CLEAR is ignored until the FSM is back in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_nx = estado;
    case (estado)
      ST_IDLE: begin
        if (clr_req) begin
          estado_nx = ST_CLEAR;
        end else if (req0 || req1) begin
          estado_nx = ST_WRITE;
        end
      end
      ST_WRITE: begin
        estado_nx = ST_IDLE;
      end
      ST_CLEAR: begin
        if (cnt == ULTIMA) begin
          estado_nx = ST_IDLE;
        end
      end
      default: begin
        estado_nx = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Outputs are registered, so this computes the values for the
  // state being entered; they then appear during the cycle spent in it.
  // The winner's addr/data are captured straight into addr_rd/data_in, which
  // doubles as the request latch. The pointer is moved to the other requester
  // on the same edge the write is issued, well before the next arbitration.
  // ---------------------------------------------------------------------------
  always_comb begin
    we_nx       = 1'b0;
    ack0_nx     = 1'b0;
    ack1_nx     = 1'b0;
    busy_nx     = 1'b0;
    clr_done_nx = 1'b0;
    addr_nx     = addr_rd;   // IDLE holds the last address and data
    data_nx     = data_in;
    ptr_nx      = ptr;
    cnt_nx      = cnt;
    case (estado)
      ST_IDLE: begin
        if (clr_req) begin
          // Clear wins over any pending request; sweep starts at address 0.
          we_nx   = 1'b1;
          busy_nx = 1'b1;
          addr_nx = '0;
          data_nx = '0;
          cnt_nx  = '0;
        end else if (req0 || req1) begin
          we_nx   = 1'b1;
          busy_nx = 1'b1;
          addr_nx = (gana == REQ_1) ? addr1 : addr0;
          data_nx = (gana == REQ_1) ? data1 : data0;
          ack0_nx = (gana == REQ_0);
          ack1_nx = (gana == REQ_1);
          ptr_nx  = ~gana;
        end
      end
      ST_WRITE: begin
        // Single write cycle; defaults return the outputs to idle values.
      end
      ST_CLEAR: begin
        if (cnt != ULTIMA) begin
          we_nx       = 1'b1;
          busy_nx     = 1'b1;
          addr_nx     = cnt_inc;
          data_nx     = '0;
          cnt_nx      = cnt_inc;
          clr_done_nx = (cnt_inc == ULTIMA);
        end else begin
          // Last clear write just went out; counter wraps for the next clear.
          cnt_nx = '0;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output, pointer and clear-counter registers. Reset aborts any write or
  // clear in flight; the pointer is untouched by clears.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we       <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      addr_rd  <= '0;
      data_in  <= '0;
      ptr      <= REQ_0;
      cnt      <= '0;
    end else begin
      we       <= we_nx;
      ack0     <= ack0_nx;
      ack1     <= ack1_nx;
      busy     <= busy_nx;
      clr_done <= clr_done_nx;
      addr_rd  <= addr_nx;
      data_in  <= data_nx;
      ptr      <= ptr_nx;
      cnt      <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
module tb_arbitro_escritura_banco;

  localparam int N     = 4;
  localparam int M     = 4;
  localparam int DEPTH = 1 << M;

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [M-1:0] addr0, addr1;
  logic [N-1:0] data0, data1;
  logic         clr_req;
  logic         ack0, ack1, we, busy, clr_done;
  logic [M-1:0] addr_rd;
  logic [N-1:0] data_in;

  int tests = 0;
  int fails = 0;

  arbitro_escritura_banco #(.N(N), .M(M)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .addr0   (addr0),
    .addr1   (addr1),
    .data0   (data0),
    .data1   (data1),
    .clr_req (clr_req),
    .ack0    (ack0),
    .ack1    (ack1),
    .we      (we),
    .addr_rd (addr_rd),
    .data_in (data_in),
    .busy    (busy),
    .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank driven by the arbiter's write port (the parent's role).
  logic [N-1:0] bank [DEPTH];
  always @(posedge clk) begin
    if (we === 1'b1) bank[addr_rd] <= data_in;
  end

  // ---------------------------------------------------------------------------
  // Reference model: a schedule of expected output cycles. When the arbiter
  // is free, a granted operation enqueues all the cycles it will occupy; each
  // edge consumes one scheduled cycle, or produces an idle cycle if none left.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic         we;
    logic         ack0;
    logic         ack1;
    logic         busy;
    logic         done;
    logic [M-1:0] addr;
    logic [N-1:0] data;
  } exp_t;

  exp_t         cur = '0;
  exp_t         sched [$];
  bit           ptr_m = 1'b0;
  bit           model_ok = 1'b0;
  logic [N-1:0] sb [DEPTH];

  always @(posedge clk) begin : model
    exp_t e;
    bit   w;
    if (model_ok && cur.we) sb[cur.addr] = cur.data;
    if (rst) begin
      sched.delete();
      ptr_m    = 1'b0;
      cur      = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (!cur.busy) begin
        if (clr_req) begin
          for (int i = 0; i < DEPTH; i++) begin
            e = '0; e.we = 1'b1; e.busy = 1'b1;
            e.addr = M'(i); e.done = (i == DEPTH - 1);
            sched.push_back(e);
          end
        end else if (req0 || req1) begin
          w = (req0 && req1) ? ptr_m : req1;
          e = '0; e.we = 1'b1; e.busy = 1'b1;
          e.addr = w ? addr1 : addr0;
          e.data = w ? data1 : data0;
          e.ack0 = !w; e.ack1 = w;
          sched.push_back(e);
          ptr_m = !w;
        end
      end
      if (sched.size() > 0) begin
        cur = sched.pop_front();
      end else begin
        e = '0; e.addr = cur.addr; e.data = cur.data;
        cur = e;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_pack();
    exp_t d;
    d.we = we; d.ack0 = ack0; d.ack1 = ack1; d.busy = busy;
    d.done = clr_done; d.addr = addr_rd; d.data = data_in;
    return 32'(d);
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) chk("cycle_vs_model", dut_pack(), 32'(cur));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; clr_req = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
  endtask

  bit           prev_ack0, prev_ack1;
  logic [N-1:0] zero_d;

  initial begin
    zero_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bank[i] = '0;
      sb[i]   = '0;
    end
    idle_inputs();
    rst = 1;
    step(); step();
    // Reset state: everything low, addr/data zero.
    chk("reset_outputs", {27'd0, we, ack0, ack1, busy, clr_done}, 32'd0);
    chk("reset_addr_data", {24'd0, addr_rd, data_in}, 32'd0);

    // Single requester 0 write.
    rst = 0; req0 = 1; addr0 = 4'd3; data0 = 4'hA;
    step();
    chk("w0_we", we, 1); chk("w0_addr", addr_rd, 3); chk("w0_data", data_in, 4'hA);
    chk("w0_ack0", ack0, 1); chk("w0_ack1", ack1, 0); chk("w0_busy", busy, 1);
    step();
    req0 = 0;
    chk("w0_idle_we", we, 0); chk("w0_idle_ack0", ack0, 0); chk("w0_idle_busy", busy, 0);
    chk("w0_idle_hold_addr", addr_rd, 3);
    chk("w0_bank3", bank[3], 4'hA);

    // Both requesters held from reset: acks alternate 0,1,0,1 every 2 cycles.
    rst = 1; req0 = 1; req1 = 1; addr0 = 4'd1; data0 = 4'h5; addr1 = 4'd2; data1 = 4'h6;
    step();
    rst = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("rr_ack0", ack0, (k % 4) == 1);
      chk("rr_ack1", ack1, (k % 4) == 3);
    end
    idle_inputs();

    // Clear with simultaneous req1: full sweep first, then req1 is granted.
    rst = 1; step(); rst = 0;
    clr_req = 1; req1 = 1; addr1 = 4'd5; data1 = 4'h9;
    step();
    clr_req = 0;
    for (int k = 0; k < DEPTH; k++) begin
      chk("clr_we", we, 1); chk("clr_data", data_in, 0);
      chk("clr_addr", addr_rd, k); chk("clr_done", clr_done, k == DEPTH - 1);
      chk("clr_ack1", ack1, 0);
      step();
    end
    chk("clr_after_we", we, 0); chk("clr_after_busy", busy, 0);
    step();
    req1 = 0;
    chk("clr_then_ack1", ack1, 1); chk("clr_then_addr", addr_rd, 5);
    chk("clr_then_data", data_in, 4'h9);
    step();

    // Reset in the middle of a clear (address 7) aborts it.
    clr_req = 1; step(); clr_req = 0;
    for (int k = 0; k < 7; k++) step();
    chk("abort_at7_addr", addr_rd, 7);
    rst = 1;
    step();
    rst = 0;
    chk("abort_we", we, 0); chk("abort_busy", busy, 0);
    chk("abort_done", clr_done, 0); chk("abort_addr", addr_rd, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("abort_no_done", clr_done, 0);
    end

    // req1 during requester 0's WRITE is ignored until IDLE, then granted.
    rst = 1; step(); rst = 0;
    req0 = 1; addr0 = 4'd2; data0 = 4'h6;
    step();
    chk("late_ack0", ack0, 1);
    req1 = 1; addr1 = 4'd4; data1 = 4'h7;
    step();
    req0 = 0;
    chk("late_idle_ack1", ack1, 0); chk("late_idle_we", we, 0);
    step();
    req1 = 0;
    chk("late_ack1", ack1, 1); chk("late_addr", addr_rd, 4); chk("late_data", data_in, 4'h7);
    step();

    // Randomized traffic with protocol-abiding requesters.
    prev_ack0 = 0; prev_ack1 = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (clr_req) clr_req = ($urandom_range(0, 1) == 0);
      else         clr_req = ($urandom_range(0, 39) == 0);
      if (!req0 || prev_ack0) begin
        req0 = ($urandom_range(0, 2) != 0);
        addr0 = M'($urandom); data0 = N'($urandom);
      end
      if (!req1 || prev_ack1) begin
        req1 = ($urandom_range(0, 2) != 0);
        addr1 = M'($urandom); data1 = N'($urandom);
      end
      prev_ack0 = ack0; prev_ack1 = ack1;
      step();
    end
    idle_inputs();
    rst = 0;
    for (int k = 0; k < DEPTH + 4; k++) step();

    // Bank contents against the scoreboard of issued writes and clears.
    for (int i = 0; i < DEPTH; i++) chk("bank_contents", bank[i], sb[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
